// File: rtl/sobel_edge_stage.sv
// -----------------------------------------------------------------------------
// sobel_edge_stage
//   Streaming 3x3 Sobel edge detector for the scaled gray pixel stream. Two
//   line buffers provide the upper taps, and a 3x3 window register is shifted
//   on every accepted pixel. Only interior centres are emitted. Each output
//   carries the magnitude |Gx|+|Gy| saturated to 8 bits, and the linear
//   address of its centre pixel.
//
//   Optional feature macro: SOBEL_THRESHOLD_EN. When it is defined, out_data
//   is binarised against THRESH (255 when sum >= THRESH, 0 otherwise).
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESET     in   asynchronous active-high reset
//   in_vsync   in   frame-start pulse; restarts the frame in any state
//   in_valid   in   in_data valid (accepted in RUN, or with in_vsync)
//   in_data    in   8-bit gray pixel, raster order
//   out_valid  out  out_data/out_addr valid
//   out_data   out  edge magnitude (or 0/255 when thresholded)
//   out_addr   out  row*IMG_W + col of the centre pixel
//   out_done   out  one-cycle pulse after the last output of a complete frame
//   busy       out  high in RUN and DRAIN
// -----------------------------------------------------------------------------
module sobel_edge_stage #(
    parameter int IMG_W  = 960,
    parameter int IMG_H  = 540,
    parameter int AW     = 19,
    parameter int THRESH = 64
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          in_vsync,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_done,
    output logic          busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Catch impossible configurations at elaboration time.
    if (IMG_W < 3 || IMG_H < 3 || (64'(1) << AW) < 64'(IMG_W) * 64'(IMG_H) ||
        THRESH < 0 || THRESH > 4095) begin : g_param_err
        $error("sobel_edge_stage: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [AW-1:0]    lin_q, lin_d;

    logic [7:0]       lb0_q [IMG_W];   // row r-2 (oldest)
    logic [7:0]       lb1_q [IMG_W];   // row r-1
    logic [2:0][2:0][7:0] win_q;       // win_q[row][col], col 2 newest

    logic [2:0]       vld_pipe_q;      // [0] window, [1] stage 1, [2] output
    logic [AW-1:0]    win_addr_q, s1_addr_q, out_addr_q;
    logic signed [10:0] gx_q, gy_q;
    logic [7:0]       out_data_q;
    logic             out_done_q;

    // A vsync cycle addresses pixel (0,0) regardless of the old counters.
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    cur_row;
    logic [AW-1:0]    cur_lin;
    logic             accept, last_px, qualify, col_wrap;
    logic [7:0]       tap0, tap1;

    assign cur_col  = in_vsync ? '0 : col_q;
    assign cur_row  = in_vsync ? '0 : row_q;
    assign cur_lin  = in_vsync ? '0 : lin_q;
    assign accept   = in_valid && (in_vsync || state_q == S_RUN);
    assign col_wrap = (cur_col == CW'(IMG_W - 1));
    assign last_px  = accept && col_wrap && (cur_row == RW'(IMG_H - 1));
    assign qualify  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign tap0     = lb0_q[cur_col];
    assign tap1     = lb1_q[cur_col];

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_vsync) state_d = S_RUN;
            S_RUN:   if (last_px)  state_d = S_DRAIN;
            S_DRAIN: if (vld_pipe_q[1:0] == 2'b00) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (in_vsync) state_d = S_RUN;
    end

    // ---------------- counters ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        lin_d = lin_q;
        if (in_vsync) begin
            col_d = '0;
            row_d = '0;
            lin_d = '0;
        end
        if (accept) begin
            if (last_px) begin
                col_d = '0;
                row_d = '0;
                lin_d = '0;
            end else begin
                col_d = col_wrap ? '0 : cur_col + CW'(1);
                row_d = col_wrap ? cur_row + RW'(1) : cur_row;
                lin_d = cur_lin + AW'(1);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lin_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lin_q   <= lin_d;
        end
    end

    // Line buffers: no reset; gating guarantees stale entries are never used.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            lb0_q[cur_col] <= tap1;
            lb1_q[cur_col] <= in_data;
        end
    end

    // ---------------- stage 1 arithmetic ----------------
    function automatic logic signed [10:0] x1(input logic [7:0] v);
        return $signed({3'b000, v});
    endfunction
    function automatic logic signed [10:0] x2(input logic [7:0] v);
        return $signed({2'b00, v, 1'b0});
    endfunction

    logic signed [10:0] gx_c, gy_c;
    assign gx_c = (x1(win_q[0][2]) + x2(win_q[1][2]) + x1(win_q[2][2]))
                - (x1(win_q[0][0]) + x2(win_q[1][0]) + x1(win_q[2][0]));
    assign gy_c = (x1(win_q[2][0]) + x2(win_q[2][1]) + x1(win_q[2][2]))
                - (x1(win_q[0][0]) + x2(win_q[0][1]) + x1(win_q[0][2]));

    // ---------------- stage 2 arithmetic ----------------
    logic [10:0] ax, ay;
    logic [11:0] sum_c;
    logic [7:0]  mag_c;
    assign ax    = gx_q[10] ? 11'(-gx_q) : gx_q;
    assign ay    = gy_q[10] ? 11'(-gy_q) : gy_q;
    assign sum_c = {1'b0, ax} + {1'b0, ay};
`ifdef SOBEL_THRESHOLD_EN
    assign mag_c = (sum_c >= 12'(THRESH)) ? 8'd255 : 8'd0;
`else
    assign mag_c = (sum_c[11:8] != 4'd0) ? 8'd255 : sum_c[7:0];
`endif

    // ---------------- pipeline ----------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            win_q      <= '0;
            vld_pipe_q <= '0;
            win_addr_q <= '0;
            s1_addr_q  <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_done_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= tap0;
                win_q[1][2] <= tap1;
                win_q[2][2] <= in_data;
                win_addr_q  <= cur_lin - AW'(IMG_W + 1);
            end
            // vsync squashes everything in flight.
            vld_pipe_q <= in_vsync ? 3'b000 : {vld_pipe_q[1:0], qualify};
            if (vld_pipe_q[0]) begin
                gx_q      <= gx_c;
                gy_q      <= gy_c;
                s1_addr_q <= win_addr_q;
            end
            if (vld_pipe_q[1] && !in_vsync) begin
                out_data_q <= mag_c;
                out_addr_q <= s1_addr_q;
            end
            out_done_q <= (state_q == S_DONE) && !in_vsync;
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_done  = out_done_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);

endmodule
